// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Holds the controller state encoding and the default operand width.
// Optional build macro used by the controller: SERIAL_SUB_BORROW_IN_EN.
package serial_sub_pkg;

   // Default operand/result width when the parent does not override it.
   localparam int SERIAL_SUB_WIDTH_DEF = 8;

   // Controller states. 2'd3 is unused; the FSM steers it back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_ctrl_fullsub.sv
// One-bit full-subtractor cell: Diff = A - B - Bin, with borrow out.
// The serial controller reuses this single cell for every bit position.
module fullsubtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   // Pure combinational difference/borrow of one bit column.
   always_comb begin
      Diff = A ^ B ^ Bin;
      Bout = (~A & B) | (~(A ^ B) & Bin);
   end

endmodule : fullsubtractor

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: computes a - b (- borrow_in) LSB first,
// one bit per clock, through a single fullsubtractor cell.
// Handshake: start accepted in IDLE or DONE; busy while RUN; done is a
// one-cycle pulse when diff/borrow_out take the new result.
// Build option: define SERIAL_SUB_BORROW_IN_EN to add the borrow_in port
// (initial borrow for chaining wider subtractions); otherwise it is 0.
module serial_subtractor_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
   input  logic             borrow_in,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   // One spare bit so the counter can reach WIDTH without wrapping.
   localparam int              CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             borrow_q, borrow_d;

   logic             cell_diff;
   logic             cell_bout;
   logic             brw_init;
   logic             accept;
   logic             in_run;
   logic             last_bit;

`ifdef SERIAL_SUB_BORROW_IN_EN
   assign brw_init = borrow_in;
`else
   assign brw_init = 1'b0;
`endif

   // A new request is taken only when no operation is in flight.
   assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign in_run   = (state_q == ST_RUN);
   assign last_bit = in_run && (cnt_q == CNT_LAST);

   // The only arithmetic in the block: current LSBs plus the running borrow.
   fullsubtractor u_cell (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .Bin  (brw_q),
      .Diff (cell_diff),
      .Bout (cell_bout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; DONE lasts one cycle unless a new start chains on.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state and the held result registers.
   always_comb begin
      busy       = (state_q == ST_RUN);
      done       = (state_q == ST_DONE);
      diff       = diff_q;
      borrow_out = borrow_q;
   end

   // Datapath next state: load on accept, shift one bit per RUN cycle,
   // publish the result only on the final bit.
   always_comb begin
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      brw_d     = brw_q;
      diff_d    = diff_q;
      borrow_d  = borrow_q;
      acc_shift = acc_q >> 1;
      acc_shift[WIDTH-1] = cell_diff;

      if (accept) begin
         a_sh_d = a;
         b_sh_d = b;
         acc_d  = '0;
         cnt_d  = '0;
         brw_d  = brw_init;
      end else if (in_run) begin
         a_sh_d = a_sh_q >> 1;
         b_sh_d = b_sh_q >> 1;
         acc_d  = acc_shift;
         brw_d  = cell_bout;
         cnt_d  = cnt_q + CNT_W'(1);
         if (last_bit) begin
            diff_d   = acc_shift;
            borrow_d = cell_bout;
         end
      end
   end

   // Datapath registers; reset clears operands, count, borrow and result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         brw_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         brw_q    <= brw_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

endmodule : serial_subtractor_ctrl

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH=8.
// Covers the borrow_in path when SERIAL_SUB_BORROW_IN_EN is defined.
module tb_serial_subtractor_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
`ifdef SERIAL_SUB_BORROW_IN_EN
   logic         borrow_in;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int checks;
   int errors;

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
      .borrow_in  (borrow_in),
`endif
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus only: issue one request, then wait (bounded) for done.
   // Returns the number of cycles from accept to done and how many of the
   // intervening cycles showed busy=1.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bin, output int lat, output int nbusy);
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
`ifdef SERIAL_SUB_BORROW_IN_EN
      borrow_in = bin;
`else
      if (bin) $display("note: borrow_in ignored in this build");
`endif
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv;   // operands may change after accept
      lat = 1; nbusy = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_SUB_BORROW_IN_EN
      borrow_in = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, diff, borrow_out} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b diff=%h bout=%b expected 0 0 00 0",
                  busy, done, diff, borrow_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, nbusy;
      do_op(8'h5A, 8'h3C, 1'b0, lat, nbusy);
      checks++;
      if (lat != 9 || nbusy != 8) begin
         errors++;
         $display("FAIL basic_latency: lat=%0d busy_cycles=%0d expected 9 8", lat, nbusy);
      end
      checks++;
      if (diff !== 8'h1E || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: diff=%h bout=%b expected 1e 0", diff, borrow_out);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h1E) begin
         errors++;
         $display("FAIL basic_idle_hold: done=%b busy=%b diff=%h expected 0 0 1e",
                  done, busy, diff);
      end
   endtask

   task automatic test_underflow();
      int lat, nbusy;
      do_op(8'h00, 8'h01, 1'b0, lat, nbusy);
      checks++;
      if (lat != 9 || diff !== 8'hFF || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL underflow_0_1: lat=%0d diff=%h bout=%b expected 9 ff 1",
                  lat, diff, borrow_out);
      end
      do_op(8'h3C, 8'h5A, 1'b0, lat, nbusy);
      checks++;
      if (lat != 9 || diff !== 8'hE2 || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL underflow_3c_5a: lat=%0d diff=%h bout=%b expected 9 e2 1",
                  lat, diff, borrow_out);
      end
      do_op(8'h77, 8'h77, 1'b0, lat, nbusy);
      checks++;
      if (diff !== 8'h00 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL equal_operands: diff=%h bout=%b expected 00 0", diff, borrow_out);
      end
   endtask

   task automatic test_start_while_busy();
      int ndone, cyc, first_done;
      // Previous result is 00/0; issue 5A-3C then poke start mid-RUN.
      @(negedge clk);
      start = 1'b1; a = 8'h5A; b = 8'h3C;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || diff !== 8'h00) begin
         errors++;
         $display("FAIL busy_hold_prev: busy=%b diff=%h expected 1 00", busy, diff);
      end
      start = 1'b1; a = 8'hFF; b = 8'h00;   // third RUN cycle: must be ignored
      @(negedge clk);
      start = 1'b0;
      ndone = 0; first_done = 0;
      for (cyc = 4; cyc <= 24; cyc++) begin
         if (done === 1'b1) begin
            ndone++;
            if (first_done == 0) first_done = cyc;
         end
         @(negedge clk);
      end
      checks++;
      if (ndone != 1 || first_done != 9) begin
         errors++;
         $display("FAIL ignore_start_pulses: done_count=%0d at=%0d expected 1 9",
                  ndone, first_done);
      end
      checks++;
      if (diff !== 8'h1E || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_result: diff=%h bout=%b expected 1e 0",
                  diff, borrow_out);
      end
   endtask

   task automatic test_back_to_back();
      int lat, nbusy;
      do_op(8'h10, 8'h20, 1'b0, lat, nbusy);   // F0, borrow 1
      checks++;
      if (done !== 1'b1 || diff !== 8'hF0 || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: done=%b diff=%h bout=%b expected 1 f0 1",
                  done, diff, borrow_out);
      end
      // Start is high during the DONE cycle: accepted immediately.
      start = 1'b1; a = 8'h80; b = 8'h01;
      @(negedge clk);
      start = 1'b0; a = 8'h00; b = 8'h00;
      lat = 1;
      checks++;
      if (busy !== 1'b1 || diff !== 8'hF0) begin
         errors++;
         $display("FAIL b2b_rerun: busy=%b diff=%h expected 1 f0", busy, diff);
      end
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 9 || diff !== 8'h7F || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: gap=%0d diff=%h bout=%b expected 9 7f 0",
                  lat, diff, borrow_out);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int ndone, lat, nbusy;
      // diff currently 7F from the previous scenario.
      @(negedge clk);
      start = 1'b1; a = 8'h5A; b = 8'h3C;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);             // now in RUN cycle 4
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b diff=%h bout=%b expected 0 00 0",
                  busy, diff, borrow_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         if (done === 1'b1 || busy === 1'b1) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone != 0 || diff !== 8'h00) begin
         errors++;
         $display("FAIL reset_abort: activity_cycles=%0d diff=%h expected 0 00", ndone, diff);
      end
      do_op(8'hC3, 8'h41, 1'b0, lat, nbusy);
      checks++;
      if (lat != 9 || diff !== 8'h82 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_op: lat=%0d diff=%h bout=%b expected 9 82 0",
                  lat, diff, borrow_out);
      end
   endtask

`ifdef SERIAL_SUB_BORROW_IN_EN
   task automatic test_borrow_in();
      int lat, nbusy;
      do_op(8'h10, 8'h05, 1'b1, lat, nbusy);
      checks++;
      if (diff !== 8'h0A || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL borrow_in_10_05: diff=%h bout=%b expected 0a 0", diff, borrow_out);
      end
      do_op(8'h00, 8'h00, 1'b1, lat, nbusy);
      checks++;
      if (diff !== 8'hFF || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL borrow_in_00_00: diff=%h bout=%b expected ff 1", diff, borrow_out);
      end
      borrow_in = 1'b0;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_underflow();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();
`ifdef SERIAL_SUB_BORROW_IN_EN
      test_borrow_in();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop in case a scenario stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule : tb_serial_subtractor_ctrl
